// File: rtl/dct_coeff_mult_pipe_pkg.sv
// Shared types for the DCT coefficient multiplier: the coefficient type, the fixed
// coefficient table, and small helpers used by the lane multiplier and the top level.
package dct_mult_pkg;

  localparam int unsigned COEFF_W = 8;
  localparam int unsigned N_COEFF = 7;

  typedef logic signed [COEFF_W-1:0] coeff_t;

  localparam coeff_t DCT_COEFF [N_COEFF] = '{
    8'sd64, 8'sd60, 8'sd56, 8'sd45, 8'sd36, 8'sd24, 8'sd12
  };

  // Indices past the table (only 7 with a 3-bit select) give a zero coefficient.
  function automatic coeff_t coeff_lookup(input logic [2:0] sel, input logic neg);
    coeff_t c;
    c = '0;
    if (32'(sel) < N_COEFF) c = DCT_COEFF[sel];
    return neg ? -c : c;
  endfunction

  // Largest positive value representable in a signed field of the given width.
  function automatic longint sat_to(input int unsigned width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

endpackage

// File: rtl/dct_coeff_mult_pipe_mult_lane.sv
// One lane of the DCT multiplier: approximation mask, signed multiply and saturation
// to the result width. Purely combinational; the top level owns all registers.
module mult_lane
  import dct_mult_pkg::*;
#(
  parameter int unsigned SIZE        = 8,
  parameter int unsigned SIZE_MULT   = SIZE + 6,
  parameter int unsigned APPROX_BITS = 0
) (
  input  logic [SIZE-1:0]      mcand_i,
  input  coeff_t               coeff_i,
  output logic [SIZE_MULT-1:0] result_o,
  output logic                 sat_o
);

  localparam int unsigned PW = SIZE + COEFF_W;
  localparam bit CLAMP = (SIZE_MULT < PW);
  localparam logic [SIZE-1:0] MASK = {SIZE{1'b1}} << APPROX_BITS;
  localparam logic signed [PW-1:0] HI = PW'(sat_to(SIZE_MULT));
  // Bitwise inverse of the positive limit is the negative limit in two's complement.
  localparam logic signed [PW-1:0] LO = ~HI;

  logic signed [SIZE-1:0] m;
  logic signed [PW-1:0]   prod;

  always_comb begin
    m    = $signed(mcand_i & MASK);
    prod = PW'(m) * PW'(coeff_i);
    if (CLAMP && (prod > HI)) begin
      result_o = SIZE_MULT'(HI);
      sat_o    = 1'b1;
    end else if (CLAMP && (prod < LO)) begin
      result_o = SIZE_MULT'(LO);
      sat_o    = 1'b1;
    end else begin
      result_o = SIZE_MULT'(prod);
      sat_o    = 1'b0;
    end
  end

endmodule

// File: rtl/dct_coeff_mult_pipe.sv
// Pipelined multi-lane coefficient multiplier for the DCT datapath with valid/ready
// handshakes; every stage advances together whenever the output slot can move.
module dct_coeff_mult_pipe
  import dct_mult_pkg::*;
#(
  parameter int unsigned SIZE        = 8,
  parameter int unsigned SIZE_MULT   = SIZE + 6,
  parameter int unsigned LANES       = 1,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned APPROX_BITS = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   coeff_sel,
  input  logic                         coeff_neg,
  input  logic [LANES*SIZE-1:0]        mcand,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*SIZE_MULT-1:0]   result,
  output logic [LANES-1:0]             sat
);

  logic                       adv;
  logic [PIPE_STAGES-1:0]     vld_q, vld_d;
  logic [LANES*SIZE-1:0]      lane_m;
  coeff_t                     lane_c;
  logic [LANES*SIZE_MULT-1:0] res_d, res_q;
  logic [LANES-1:0]           sat_d, sat_q;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[PIPE_STAGES-1];
  assign result    = res_q;
  assign sat       = sat_q;

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = in_valid;
    for (int unsigned i = 1; i < PIPE_STAGES; i++) vld_d[i] = vld_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_q <= '0;
    else if (adv) vld_q <= vld_d;
  end

  // A single stage multiplies straight from the inputs; deeper pipes register operands first.
  if (PIPE_STAGES == 1) begin : g_merged
    assign lane_m = mcand;
    assign lane_c = coeff_lookup(coeff_sel, coeff_neg);
  end else begin : g_split
    logic [LANES*SIZE-1:0] op_m_q [PIPE_STAGES-1];
    coeff_t                op_c_q [PIPE_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < PIPE_STAGES - 1; i++) begin
          op_m_q[i] <= '0;
          op_c_q[i] <= '0;
        end
      end else if (adv) begin
        op_m_q[0] <= mcand;
        op_c_q[0] <= coeff_lookup(coeff_sel, coeff_neg);
        for (int unsigned i = 1; i < PIPE_STAGES - 1; i++) begin
          op_m_q[i] <= op_m_q[i-1];
          op_c_q[i] <= op_c_q[i-1];
        end
      end
    end

    assign lane_m = op_m_q[PIPE_STAGES-2];
    assign lane_c = op_c_q[PIPE_STAGES-2];
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mult_lane #(
      .SIZE        (SIZE),
      .SIZE_MULT   (SIZE_MULT),
      .APPROX_BITS (APPROX_BITS)
    ) u_lane (
      .mcand_i  (lane_m[g*SIZE +: SIZE]),
      .coeff_i  (lane_c),
      .result_o (res_d[g*SIZE_MULT +: SIZE_MULT]),
      .sat_o    (sat_d[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      sat_q <= '0;
    end else if (adv) begin
      res_q <= res_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_dct_coeff_mult_pipe.sv
// Bench for dct_coeff_mult_pipe: three instances (defaults, 4 lanes / 3 stages,
// 1 stage with approximation) checked against an arithmetic model and a scoreboard.
module tb_dct_coeff_mult_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0 = 1'b0, neg0 = 1'b0, ordy0 = 1'b1;
  logic [2:0]  sel0 = '0;
  logic [7:0]  m0 = '0;
  logic        r0, ov0, sat0;
  logic [13:0] res0;

  logic        vA = 1'b0, negA = 1'b0, ordyA = 1'b1;
  logic [2:0]  selA = '0;
  logic [31:0] mA = '0;
  logic        rA, ovA;
  logic [55:0] resA;
  logic [3:0]  satA;

  logic        vB = 1'b0, negB = 1'b0, ordyB = 1'b1;
  logic [2:0]  selB = '0;
  logic [7:0]  mB = '0;
  logic        rB, ovB, satB;
  logic [13:0] resB;

  dct_coeff_mult_pipe u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .coeff_sel(sel0),
    .coeff_neg(neg0), .mcand(m0), .out_valid(ov0), .out_ready(ordy0),
    .result(res0), .sat(sat0));

  dct_coeff_mult_pipe #(.LANES(4), .PIPE_STAGES(3)) u_dutA (
    .clk(clk), .rst_n(rst_n), .in_valid(vA), .in_ready(rA), .coeff_sel(selA),
    .coeff_neg(negA), .mcand(mA), .out_valid(ovA), .out_ready(ordyA),
    .result(resA), .sat(satA));

  dct_coeff_mult_pipe #(.PIPE_STAGES(1), .APPROX_BITS(2)) u_dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(vB), .in_ready(rB), .coeff_sel(selB),
    .coeff_neg(negB), .mcand(mB), .out_valid(ovB), .out_ready(ordyB),
    .result(resB), .sat(satB));

  typedef struct {
    logic [55:0] res;
    logic [3:0]  sat;
    int          stamp;
  } exp_t;

  exp_t q0[$], qA[$], qB[$];
  int   compared = 0, mismatched = 0, cyc = 0;
  bit   chk_lat = 1'b1, rnd = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: clear low bits, multiply by the signed table coefficient, clamp.
  function automatic int model(input int m, input int sel, input bit neg,
                               input int approx, input int smult, output bit s);
    int c, p, hi;
    m = (m >>> approx) <<< approx;
    case (sel)
      0: c = 64; 1: c = 60; 2: c = 56; 3: c = 45;
      4: c = 36; 5: c = 24; 6: c = 12; default: c = 0;
    endcase
    if (neg) c = -c;
    p  = m * c;
    hi = (1 << (smult - 1)) - 1;
    s  = 1'b1;
    if (p > hi) return hi;
    if (p < -hi - 1) return -hi - 1;
    s = 1'b0;
    return p;
  endfunction

  always @(negedge rst_n) begin
    q0.delete(); qA.delete(); qB.delete();
  end

  always @(posedge clk) begin
    exp_t e;
    bit   s;
    cyc++;
    if (rst_n) begin
      if (v0 && r0) begin
        e.res = '0; e.sat = '0; e.stamp = cyc;
        e.res[13:0] = 14'(model($signed(m0), int'(sel0), neg0, 0, 14, s));
        e.sat[0] = s;
        q0.push_back(e);
      end
      if (vA && rA) begin
        e.res = '0; e.sat = '0; e.stamp = cyc;
        for (int i = 0; i < 4; i++) begin
          e.res[i*14 +: 14] = 14'(model($signed(mA[i*8 +: 8]), int'(selA), negA, 0, 14, s));
          e.sat[i] = s;
        end
        qA.push_back(e);
      end
      if (vB && rB) begin
        e.res = '0; e.sat = '0; e.stamp = cyc;
        e.res[13:0] = 14'(model($signed(mB), int'(selB), negB, 2, 14, s));
        e.sat[0] = s;
        qB.push_back(e);
      end
    end
  end

  bit          st0 = 1'b0;
  logic [13:0] pr0;
  logic        pst0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) st0 = 1'b0;
    else begin
      if (st0) begin
        check("stall_valid", ov0, 1);
        check("stall_result", res0, pr0);
        check("stall_sat", sat0, pst0);
      end
      if (ov0 && ordy0) begin
        check("beat0_expected", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          check("res0", res0, e.res[13:0]);
          check("sat0", sat0, e.sat[0]);
          if (chk_lat) check("latency0", cyc - e.stamp + 1, 2);
        end
      end
      st0 = ov0 && !ordy0; pr0 = res0; pst0 = sat0;
      if (ovA && ordyA) begin
        check("beatA_expected", qA.size() > 0, 1);
        if (qA.size() > 0) begin
          e = qA.pop_front();
          for (int i = 0; i < 4; i++) begin
            check($sformatf("resA_lane%0d", i), resA[i*14 +: 14], e.res[i*14 +: 14]);
            check($sformatf("satA_lane%0d", i), satA[i], e.sat[i]);
          end
          check("latencyA", cyc - e.stamp + 1, 3);
        end
      end
      if (ovB && ordyB) begin
        check("beatB_expected", qB.size() > 0, 1);
        if (qB.size() > 0) begin
          e = qB.pop_front();
          check("resB", resB, e.res[13:0]);
          check("satB", satB, e.sat[0]);
          check("latencyB", cyc - e.stamp + 1, 1);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    ordy0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic logic rdy(input int d);
    case (d)
      0:       return r0;
      1:       return rA;
      default: return rB;
    endcase
  endfunction

  function automatic logic ovd(input int d);
    case (d)
      0:       return ov0;
      1:       return ovA;
      default: return ovB;
    endcase
  endfunction

  // Called and returning 1 time unit after a rising edge, so each beat is held for exactly one edge.
  task automatic send(input int d, input logic [31:0] m, input int sel, input bit neg);
    bit ok = 1'b0;
    case (d)
      0:       begin v0 = 1'b1; m0 = m[7:0]; sel0 = 3'(sel); neg0 = neg; end
      1:       begin vA = 1'b1; mA = m;      selA = 3'(sel); negA = neg; end
      default: begin vB = 1'b1; mB = m[7:0]; selB = 3'(sel); negB = neg; end
    endcase
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = rdy(d);
    end
    if (!ok) check($sformatf("send%0d_ready", d), rdy(d), 1);
    @(posedge clk); #1;
    case (d)
      0:       v0 = 1'b0;
      1:       vA = 1'b0;
      default: vB = 1'b0;
    endcase
  endtask

  task automatic wait_out(input int d, input string name, input logic [55:0] exp_res,
                          input logic [3:0] exp_sat);
    bit got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = ovd(d);
    end
    check({name, "_valid"}, got, 1);
    case (d)
      0: begin
        check({name, "_res"}, res0, exp_res[13:0]);
        check({name, "_sat"}, sat0, exp_sat[0]);
      end
      1: begin
        check({name, "_res"}, resA, exp_res);
        check({name, "_sat"}, satA, exp_sat);
      end
      default: begin
        check({name, "_res"}, resB, exp_res[13:0]);
        check({name, "_sat"}, satB, exp_sat[0]);
      end
    endcase
    @(posedge clk); #1;
  endtask

  task automatic drain;
    for (int n = 0; n < 300 && (q0.size() + qA.size() + qB.size()) != 0; n++) @(negedge clk);
    check("drain_q0", q0.size(), 0);
    check("drain_qA", qA.size(), 0);
    check("drain_qB", qB.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s;
    int c0;

    check("model_sat_pos", model(-128, 0, 1, 0, 14, s), 8191);
    check("model_sat_pos_flag", s, 1);
    check("model_neg_max", model(127, 0, 1, 0, 14, s), -8128);
    check("model_neg_max_flag", s, 0);
    check("model_approx_pos", model(7, 2, 0, 2, 14, s), 224);
    check("model_approx_neg", model(-7, 2, 0, 2, 14, s), -448);
    check("model_lane", model(100, 3, 0, 0, 14, s), 4500);
    check("model_sel7", model(-77, 7, 1, 0, 14, s), 0);

    repeat (2) @(posedge clk); #1;
    check("reset_valid0", ov0, 0);
    check("reset_res0", res0, 0);
    check("reset_sat0", sat0, 0);
    check("reset_validA", ovA, 0);
    check("reset_resA", resA, 0);
    check("reset_validB", ovB, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", r0, 1);

    c0 = cyc;
    for (int m = -128; m <= 127; m++) send(0, m, 1, 1'b0);
    check("sweep_cycles", cyc - c0, 256);
    drain();

    send(0, -128, 0, 1'b1);
    send(0, 127, 0, 1'b1);
    wait_out(0, "sat_pos", 56'(8191), 4'b0001);
    wait_out(0, "neg_max", {42'b0, 14'(-8128)}, 4'b0000);

    chk_lat = 1'b0;
    rnd     = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(0, $urandom_range(0, 255), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd = 1'b0;
    drain();
    chk_lat = 1'b1;

    send(1, {8'hFF, 8'h02, 8'hFD, 8'h64}, 3, 1'b0);
    wait_out(1, "lanes4", {14'(-45), 14'(90), 14'(-135), 14'(4500)}, 4'b0000);
    send(1, {8'hFF, 8'h02, 8'hFD, 8'h64}, 7, 1'b1);
    wait_out(1, "lanes4_sel7", '0, 4'b0000);
    send(1, {8'h80, 8'h7F, 8'h00, 8'h01}, 0, 1'b1);
    wait_out(1, "lanes4_sat", {14'(8191), 14'(-8128), 14'(0), 14'(-64)}, 4'b1000);

    send(2, 7, 2, 1'b0);
    wait_out(2, "approx_pos", 56'(224), 4'b0000);
    send(2, -7, 2, 1'b0);
    wait_out(2, "approx_neg", {42'b0, 14'(-448)}, 4'b0000);
    drain();

    send(0, 5, 1, 1'b0);
    send(0, -6, 2, 1'b0);
    check("inflight_valid", ov0, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", ov0, 0);
    check("async_rst_res", res0, 0);
    check("async_rst_sat", sat0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_release_ready", r0, 1);
    repeat (4) begin
      @(negedge clk);
      check("no_stale_beat", ov0, 0);
    end
    @(posedge clk); #1;
    send(0, 10, 3, 1'b0);
    wait_out(0, "post_reset", 56'(450), 4'b0000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
